// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: trivial ops (x0 multiply, divide by zero, overflow) skip CALC/FIX.
module muldiv_unit #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        wb_we
);

  localparam int unsigned Iters = 32 / STEPS_PER_CYCLE;
  localparam logic [4:0] CntInit = 5'(Iters - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic        div0_q, div0_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  // Operand decode at acceptance
  logic        is_mul_in, sgn_a_in, sgn_b_in, neg_a, neg_b, accept;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    is_mul_in = ~funct3[2];
    sgn_a_in  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_in  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a     = sgn_a_in & op_a[31];
    neg_b     = sgn_b_in & op_b[31];
    mag_a     = neg_a ? -op_a : op_a;
    mag_b     = neg_b ? -op_b : op_b;
    accept    = start & ~flush & ((state_q == StIdle) || (state_q == StDone));
  end

  logic        early_hit;
  logic [31:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (is_mul_in) begin
      early_hit = (op_a == '0) || (op_b == '0);
    end else if (op_b == '0) begin
      early_hit = 1'b1;
      early_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else if (!funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
      early_hit = 1'b1;
      early_res = funct3[1] ? 32'h0 : 32'h8000_0000;
    end
  end
`else
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
  end
`endif

  // STEPS_PER_CYCLE radix-2 iterations on the accumulator
  logic [63:0] acc_step;
  logic [32:0] add;
  logic [33:0] diff;

  always_comb begin
    acc_step = acc_q;
    add      = '0;
    diff     = '0;
    for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (!f3_q[2]) begin
        add      = {1'b0, acc_step[63:32]} + (acc_step[0] ? {1'b0, opnd_q} : 33'd0);
        acc_step = {add, acc_step[31:1]};
      end else begin
        // Upper half is remainder, lower half shifts in quotient bits
        diff = {1'b0, acc_step[63:31]} - {2'b00, opnd_q};
        if (!diff[33]) begin
          acc_step = {diff[31:0], acc_step[30:0], 1'b1};
        end else begin
          acc_step = {acc_step[62:0], 1'b0};
        end
      end
    end
  end

  // Sign correction and result selection
  logic [63:0] prod;
  logic [31:0] quot, rem, fix_res;

  always_comb begin
    prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot    = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
    rem     = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
    fix_res = '0;
    unique case (f3_q)
      3'b000:                 fix_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
      3'b100, 3'b101:         fix_res = div0_q ? 32'hFFFF_FFFF : quot;
      3'b110, 3'b111:         fix_res = rem;  // divide by zero leaves |a| here, re-signed to op_a
      default:                fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          f3_d     = funct3;
          rd_d     = rd_in;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          div0_d   = (op_b == '0);
          opnd_d   = is_mul_in ? mag_a : mag_b;
          acc_d    = {32'h0, is_mul_in ? mag_b : mag_a};
          cnt_d    = CntInit;
          if (early_hit) begin
            result_d = early_res;
            rd_out_d = rd_in;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == '0) state_d = StFix;
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          rd_out_d = rd_q;
          state_d  = StDone;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      f3_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_comb begin
    busy   = (state_q == StCalc) || (state_q == StFix);
    done   = (state_q == StDone);
    result = result_q;
    rd_out = rd_out_q;
    wb_we  = done & (rd_out_q != '0);
  end

endmodule
